// File: rtl/noc_node_injector.sv
// noc_node_injector: PE-side injection interface for one mesh node. Buffers requests and emits
// each one as a HEAD/TAIL flit pair. Define NOC_INJ_PARITY_EN to append an even-parity MSB.
module noc_node_injector #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned COORD_W    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SRC_X      = 0,
  parameter int unsigned SRC_Y      = 0,
`ifdef NOC_INJ_PARITY_EN
  localparam int unsigned FLIT_W    = DATA_W + 3
`else
  localparam int unsigned FLIT_W    = DATA_W + 2
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pe_valid,
  output logic               pe_ready,
  input  logic [COORD_W-1:0] pe_dst_x,
  input  logic [COORD_W-1:0] pe_dst_y,
  input  logic [DATA_W-1:0]  pe_data,
  output logic               pe_err,
  output logic               flit_valid,
  input  logic               flit_ready,
  output logic [FLIT_W-1:0]  flit_data,
  output logic               pkt_sent
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = DATA_W + 2 * COORD_W;
  localparam int unsigned PAD_W   = DATA_W - 4 * COORD_W - 8;

  localparam logic [COORD_W-1:0] SrcX      = COORD_W'(SRC_X);
  localparam logic [COORD_W-1:0] SrcY      = COORD_W'(SRC_Y);
  localparam logic [1:0]         TypeHead  = 2'b01;
  localparam logic [1:0]         TypeTail  = 2'b10;
  localparam logic [PTR_W:0]     FullCount = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StHead, StTail} state_e;

  // Request FIFO: entry = {dst_y, dst_x, data}
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               push, pop, fifo_empty, self_addr;
  logic [ENTRY_W-1:0] head_entry;
  logic               pe_err_q;

  state_e             state_q, state_d;
  logic [FLIT_W-1:0]  flit_q, flit_d;
  logic [DATA_W-1:0]  payload_q, payload_d;
  logic [7:0]         seq_q, seq_d;

  function automatic logic [FLIT_W-1:0] make_flit(input logic [1:0]        typ,
                                                   input logic [DATA_W-1:0] body);
`ifdef NOC_INJ_PARITY_EN
    return {^{typ, body}, typ, body};
`else
    return {typ, body};
`endif
  endfunction

  function automatic logic [DATA_W-1:0] head_body(input logic [7:0]         seq,
                                                  input logic [ENTRY_W-1:0] entry);
    return {{PAD_W{1'b0}}, seq, SrcY, SrcX,
            entry[DATA_W+COORD_W +: COORD_W], entry[DATA_W +: COORD_W]};
  endfunction

  assign fifo_empty = (count_q == '0);
  assign pe_ready   = (count_q != FullCount);
  assign self_addr  = (pe_dst_x == SrcX) && (pe_dst_y == SrcY);
  assign push       = pe_valid & pe_ready & ~self_addr;
  assign head_entry = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pe_dst_y, pe_dst_x, pe_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pe_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
      // Self-addressed requests are handshaken but dropped
      pe_err_q <= pe_valid & pe_ready & self_addr;
    end
  end

  always_comb begin
    state_d   = state_q;
    flit_d    = flit_q;
    payload_d = payload_q;
    seq_d     = seq_q;
    pop       = 1'b0;
    pkt_sent  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          payload_d = head_entry[DATA_W-1:0];
          flit_d    = make_flit(TypeHead, head_body(seq_q, head_entry));
          state_d   = StHead;
        end
      end
      StHead: begin
        if (flit_ready) begin
          flit_d  = make_flit(TypeTail, payload_q);
          state_d = StTail;
        end
      end
      StTail: begin
        if (flit_ready) begin
          pkt_sent = 1'b1;
          seq_d    = seq_q + 8'd1;
          // Chain straight into the next HEAD so packets go out back-to-back
          if (!fifo_empty) begin
            pop       = 1'b1;
            payload_d = head_entry[DATA_W-1:0];
            flit_d    = make_flit(TypeHead, head_body(seq_d, head_entry));
            state_d   = StHead;
          end else begin
            flit_d  = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        flit_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      flit_q    <= '0;
      payload_q <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      flit_q    <= flit_d;
      payload_q <= payload_d;
      seq_q     <= seq_d;
    end
  end

  assign flit_valid = (state_q != StIdle);
  assign flit_data  = flit_q;
  assign pe_err     = pe_err_q;

endmodule

// File: tb/tb_noc_node_injector.sv
// tb_noc_node_injector: directed vector table plus hand-written multi-cycle sequences for the
// injector at SRC=(0,0). Honours NOC_INJ_PARITY_EN when building expected flits.
module tb_noc_node_injector;

  localparam int DATA_W = 32;
`ifdef NOC_INJ_PARITY_EN
  localparam int FLIT_W = DATA_W + 3;
`else
  localparam int FLIT_W = DATA_W + 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pe_valid = 1'b0;
  logic              pe_ready;
  logic [1:0]        pe_dst_x = '0;
  logic [1:0]        pe_dst_y = '0;
  logic [DATA_W-1:0] pe_data = '0;
  logic              pe_err;
  logic              flit_valid;
  logic              flit_ready = 1'b0;
  logic [FLIT_W-1:0] flit_data;
  logic              pkt_sent;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc_node_injector dut (
    .clk        (clk),
    .rst        (rst),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .pe_dst_x   (pe_dst_x),
    .pe_dst_y   (pe_dst_y),
    .pe_data    (pe_data),
    .pe_err     (pe_err),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_data  (flit_data),
    .pkt_sent   (pkt_sent)
  );

  typedef struct {
    logic              pv;
    logic [1:0]        dx;
    logic [1:0]        dy;
    logic [DATA_W-1:0] data;
    logic              fr;
    logic              exp_ready;
    logic              exp_err;
    logic              exp_fv;
    logic              exp_sent;
    logic [FLIT_W-1:0] exp_flit;
  } vec_t;

  vec_t vt[$];

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [DATA_W-1:0] b);
`ifdef NOC_INJ_PARITY_EN
    return {^{t, b}, t, b};
`else
    return {t, b};
`endif
  endfunction

  function automatic logic [FLIT_W-1:0] head(input logic [7:0] seq, input logic [1:0] dx,
                                              input logic [1:0] dy);
    logic [DATA_W-1:0] b;
    b = {16'h0, seq, 2'b00, 2'b00, dy, dx};
    return mk(2'b01, b);
  endfunction

  function automatic logic [FLIT_W-1:0] tail(input logic [DATA_W-1:0] d);
    return mk(2'b10, d);
  endfunction

  function automatic void add(input logic pv, input logic [1:0] dx, input logic [1:0] dy,
                              input logic [DATA_W-1:0] data, input logic fr, input logic er,
                              input logic fv, input logic sent, input logic [FLIT_W-1:0] f);
    vec_t v;
    v.pv = pv; v.dx = dx; v.dy = dy; v.data = data; v.fr = fr;
    v.exp_ready = 1'b1; v.exp_err = er; v.exp_fv = fv; v.exp_sent = sent; v.exp_flit = f;
    vt.push_back(v);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkf(input string name, input logic [FLIT_W-1:0] act,
                      input logic [FLIT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] dx, input logic [1:0] dy,
                       input logic [DATA_W-1:0] data, input logic fr);
    @(negedge clk);
    pe_valid = pv; pe_dst_x = dx; pe_dst_y = dy; pe_data = data; flit_ready = fr;
    #1;
  endtask

  // Push one request, wait (bounded) for its HEAD, then check HEAD, TAIL and pkt_sent
  task automatic send_pkt(input string tag, input logic [1:0] dx, input logic [1:0] dy,
                          input logic [DATA_W-1:0] data, input logic [7:0] exp_seq);
    int t;
    drive(1'b1, dx, dy, data, 1'b1);
    chk1({tag, " pe_ready"}, pe_ready, 1'b1);
    drive(1'b0, 2'd0, 2'd0, '0, 1'b1);
    t = 0;
    while (!flit_valid && t < 8) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk1({tag, " head valid"}, flit_valid, 1'b1);
    chkf({tag, " head"}, flit_data, head(exp_seq, dx, dy));
    @(negedge clk);
    #1;
    chkf({tag, " tail"}, flit_data, tail(data));
    chk1({tag, " pkt_sent"}, pkt_sent, 1'b1);
  endtask

  initial begin
    // Single packet, 5-cycle stall, self-addressed drop
    add(1'b1, 2'd2, 2'd1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, '0);
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, mk(2'b01, 32'h0000_0006));
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, mk(2'b10, 32'hDEADBEEF));
    add(1'b1, 2'd1, 2'd0, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 2'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, mk(2'b01, 32'h0000_0101));
    end
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, mk(2'b01, 32'h0000_0101));
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, mk(2'b10, 32'h11111111));
    add(1'b1, 2'd0, 2'd0, 32'h5,        1'b1, 1'b0, 1'b0, 1'b0, '0);
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, '0);
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, '0);
    add(1'b0, 2'd0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst pe_ready", pe_ready, 1'b1);
    chk1("rst flit_valid", flit_valid, 1'b0);
    chkf("rst flit_data", flit_data, '0);
    chk1("rst pe_err", pe_err, 1'b0);
    chk1("rst pkt_sent", pkt_sent, 1'b0);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].pv, vt[i].dx, vt[i].dy, vt[i].data, vt[i].fr);
      chk1($sformatf("vec%0d pe_ready", i), pe_ready, vt[i].exp_ready);
      chk1($sformatf("vec%0d pe_err", i), pe_err, vt[i].exp_err);
      chk1($sformatf("vec%0d flit_valid", i), flit_valid, vt[i].exp_fv);
      chk1($sformatf("vec%0d pkt_sent", i), pkt_sent, vt[i].exp_sent);
      if (vt[i].exp_fv) chkf($sformatf("vec%0d flit_data", i), flit_data, vt[i].exp_flit);
    end

    // Fill with router stalled: one request sits in the flit register, four in the FIFO
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd3, 2'(i % 4), 32'hA0 + i, 1'b0);
      chk1($sformatf("fill%0d pe_ready", i), pe_ready, (i < 5) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 2'd0, 2'd0, '0, 1'b0);
    chk1("full hold pe_ready", pe_ready, 1'b0);
    chk1("full hold flit_valid", flit_valid, 1'b1);
    for (int p = 0; p < 5; p++) begin
      drive(1'b0, 2'd0, 2'd0, '0, 1'b1);
      chkf($sformatf("b2b head%0d", p), flit_data, head(8'(2 + p), 2'd3, 2'(p % 4)));
      chk1($sformatf("b2b head%0d valid", p), flit_valid, 1'b1);
      chk1($sformatf("b2b head%0d sent", p), pkt_sent, 1'b0);
      drive(1'b0, 2'd0, 2'd0, '0, 1'b1);
      chkf($sformatf("b2b tail%0d", p), flit_data, tail(32'hA0 + p));
      chk1($sformatf("b2b tail%0d sent", p), pkt_sent, 1'b1);
    end
    drive(1'b0, 2'd0, 2'd0, '0, 1'b1);
    chk1("b2b drained", flit_valid, 1'b0);
    chk1("b2b pe_ready", pe_ready, 1'b1);

    // Asynchronous reset while a TAIL is stalled and another request is queued
    drive(1'b1, 2'd1, 2'd2, 32'h77, 1'b0);
    drive(1'b1, 2'd2, 2'd2, 32'h88, 1'b0);
    drive(1'b0, 2'd0, 2'd0, '0, 1'b1);
    drive(1'b0, 2'd0, 2'd0, '0, 1'b0);
    chkf("pre-rst tail", flit_data, tail(32'h77));
    #2 rst = 1'b1;
    #1;
    chk1("async rst flit_valid", flit_valid, 1'b0);
    chk1("async rst pe_ready", pe_ready, 1'b1);
    chk1("async rst pkt_sent", pkt_sent, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd0, 2'd0, '0, 1'b1);
    drive(1'b0, 2'd0, 2'd0, '0, 1'b1);
    chk1("post-rst fifo flushed", flit_valid, 1'b0);

    // 258 packets from seq 0: covers 255 -> 0 -> 1 wrap
    for (int k = 0; k < 258; k++) begin
      send_pkt($sformatf("pkt%0d", k), 2'(1 + k % 3), 2'(k % 4), 32'h1000_0000 + k, 8'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
